// File: rtl/nibble_adder_seq_if.sv
// Requester/adder bus of nibble_adder_seq. The ovf signal exists only when
// NIBBLE_ADDER_SEQ_OVF_EN is defined.
interface nibble_adder_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;
`ifdef NIBBLE_ADDER_SEQ_OVF_EN
  logic         ovf;

  modport master (
    output start, op_a, op_b, cin, add_s, add_cout,
    input  ready, done, sum, cout, add_a, add_b, add_cin, ovf
  );
  modport slave (
    input  start, op_a, op_b, cin, add_s, add_cout,
    output ready, done, sum, cout, add_a, add_b, add_cin, ovf
  );
`else
  modport master (
    output start, op_a, op_b, cin, add_s, add_cout,
    input  ready, done, sum, cout, add_a, add_b, add_cin
  );
  modport slave (
    input  start, op_a, op_b, cin, add_s, add_cout,
    output ready, done, sum, cout, add_a, add_b, add_cin
  );
`endif
endinterface

// File: rtl/nibble_adder_seq.sv
// Wide adder built by time-multiplexing one external 4-bit adder, LS nibble first.
// Optional two's-complement overflow output enabled by NIBBLE_ADDER_SEQ_OVF_EN.
module nibble_adder_seq #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  nibble_adder_seq_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               carry_q;
  logic               cout_q;
  logic [IDX_W-1:0]   idx_q;
  logic               ready_q;
  logic               done_q;
  logic [IDX_W+1:0]   base_d;
  logic               last_d;

  assign base_d = {idx_q, 2'b00};
  assign last_d = (idx_q == IDX_W'(NIBBLES - 1));

`ifdef NIBBLE_ADDER_SEQ_OVF_EN
  logic ovf_q;
  logic ovf_d;
  // Operands share a sign but the result's top bit differs from it.
  assign ovf_d   = (a_q[W-1] == b_q[W-1]) && (bus.add_s[3] != a_q[W-1]);
  assign bus.ovf = ovf_q;
`endif

  // The adder loop is combinational: operand slices go out, S/Cout come back same cycle.
  always_comb begin
    bus.add_a   = 4'h0;
    bus.add_b   = 4'h0;
    bus.add_cin = 1'b0;
    if (state_q == RUN) begin
      bus.add_a   = a_q[base_d +: 4];
      bus.add_b   = b_q[base_d +: 4];
      bus.add_cin = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef NIBBLE_ADDER_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            carry_q <= bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= RUN;
`ifdef NIBBLE_ADDER_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_q[base_d +: 4] <= bus.add_s;
          carry_q            <= bus.add_cout;
          if (last_d) begin
            idx_q   <= '0;
            cout_q  <= bus.add_cout;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef NIBBLE_ADDER_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
endmodule

// File: tb/tb_nibble_adder_seq.sv
// Directed bench for nibble_adder_seq (NIBBLES=4) with a behavioural 4-bit adder.
module tb_nibble_adder_seq;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  nibble_adder_seq_if #(.NIBBLES(4)) bus ();

  nibble_adder_seq #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // External 4-bit full adder
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'h0, bus.add_cin};

  int          done_at;
  int          done_cnt;
  logic [15:0] res_sum;
  logic        res_cout;
  logic        res_ovf;
  logic        ready_tr [1:8];
  logic        cin_tr   [1:8];

  // Launch one operation from a negedge with the DUT idle, then observe 8 negedges.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input int inject_at);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = 16'hDEAD;
    bus.op_b  = 16'hBEEF;
    bus.cin   = 1'b1;
    done_at   = 0;
    done_cnt  = 0;
    res_sum   = 16'hxxxx;
    res_cout  = 1'bx;
    res_ovf   = 1'bx;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      ready_tr[n] = bus.ready;
      cin_tr[n]   = bus.add_cin;
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
        res_sum  = bus.sum;
        res_cout = bus.cout;
`ifdef NIBBLE_ADDER_SEQ_OVF_EN
        res_ovf  = bus.ovf;
`endif
      end
      if (n == inject_at) begin
        bus.start = 1'b1;
        bus.op_a  = 16'hAAAA;
        bus.op_b  = 16'h5555;
        bus.cin   = 1'b1;
      end else if (n == inject_at + 1) begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
    checks++; if (bus.add_a !== 4'h0 || bus.add_b !== 4'h0 || bus.add_cin !== 1'b0) begin
      errors++; $display("FAIL reset_adder_drive: got a=%h b=%h cin=%b want 0/0/0", bus.add_a, bus.add_b, bus.add_cin);
    end
`ifdef NIBBLE_ADDER_SEQ_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
`endif
  endtask

  task automatic test_basic();
    run_op(16'h1234, 16'h5678, 1'b0, 0);
    checks++; if (res_sum !== 16'h68AC) begin errors++; $display("FAIL basic_sum: got %h want 68ac", res_sum); end
    checks++; if (res_cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b want 0", res_cout); end
    checks++; if (done_at !== 5) begin errors++; $display("FAIL basic_done_latency: got %0d want 5", done_at); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_width: got %0d want 1", done_cnt); end
    checks++; if (ready_tr[1] !== 1'b0 || ready_tr[5] !== 1'b0 || ready_tr[6] !== 1'b1) begin
      errors++; $display("FAIL basic_ready: got r1=%b r5=%b r6=%b want 0 0 1", ready_tr[1], ready_tr[5], ready_tr[6]);
    end
    checks++; if (bus.sum !== 16'h68AC || bus.cout !== 1'b0) begin
      errors++; $display("FAIL basic_hold: got %h/%b want 68ac/0", bus.sum, bus.cout);
    end
    checks++; if (bus.add_a !== 4'h0 || bus.add_b !== 4'h0 || bus.add_cin !== 1'b0) begin
      errors++; $display("FAIL idle_adder_drive: got a=%h b=%h cin=%b want 0/0/0", bus.add_a, bus.add_b, bus.add_cin);
    end
  endtask

  task automatic test_carry_chain();
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    checks++; if (res_sum !== 16'h0000) begin errors++; $display("FAIL chain_sum: got %h want 0000", res_sum); end
    checks++; if (res_cout !== 1'b1) begin errors++; $display("FAIL chain_cout: got %b want 1", res_cout); end
    checks++; if ({cin_tr[1], cin_tr[2], cin_tr[3], cin_tr[4]} !== 4'b0111) begin
      errors++; $display("FAIL chain_add_cin: got %b%b%b%b want 0111", cin_tr[1], cin_tr[2], cin_tr[3], cin_tr[4]);
    end
  endtask

  task automatic test_cin();
    run_op(16'h0000, 16'hFFFF, 1'b1, 0);
    checks++; if ({res_cout, res_sum} !== 17'h1_0000) begin
      errors++; $display("FAIL cin_wrap: got %b/%h want 1/0000", res_cout, res_sum);
    end
    checks++; if (cin_tr[1] !== 1'b1) begin errors++; $display("FAIL cin_first_nibble: got %b want 1", cin_tr[1]); end
    run_op(16'h0006, 16'h0001, 1'b1, 0);
    checks++; if ({res_cout, res_sum} !== 17'h0_0008) begin
      errors++; $display("FAIL cin_small: got %b/%h want 0/0008", res_cout, res_sum);
    end
    run_op(16'h8000, 16'h8000, 1'b1, 0);
    checks++; if ({res_cout, res_sum} !== 17'h1_0001) begin
      errors++; $display("FAIL msb_carry: got %b/%h want 1/0001", res_cout, res_sum);
    end
  endtask

  task automatic test_start_ignored();
    run_op(16'h1111, 16'h2222, 1'b0, 2);
    checks++; if ({res_cout, res_sum} !== 17'h0_3333) begin
      errors++; $display("FAIL busy_result: got %b/%h want 0/3333", res_cout, res_sum);
    end
    checks++; if (ready_tr[2] !== 1'b0 || ready_tr[3] !== 1'b0 || ready_tr[5] !== 1'b0) begin
      errors++; $display("FAIL busy_ready: got r2=%b r3=%b r5=%b want 0 0 0", ready_tr[2], ready_tr[3], ready_tr[5]);
    end
    checks++; if (done_at !== 5 || done_cnt !== 1) begin
      errors++; $display("FAIL busy_done: got at=%0d cnt=%0d want 5 1", done_at, done_cnt);
    end
    checks++; if (ready_tr[8] !== 1'b1 || bus.sum !== 16'h3333) begin
      errors++; $display("FAIL busy_no_queue: got ready=%b sum=%h want 1 3333", ready_tr[8], bus.sum);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    bus.op_a  = 16'h1234;
    bus.op_b  = 16'h5678;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.ready !== 1'b1 || bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_state: got ready=%b sum=%h cout=%b done=%b want 1 0000 0 0",
                         bus.ready, bus.sum, bus.cout, bus.done);
    end
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    run_op(16'h0F0F, 16'h0101, 1'b0, 0);
    checks++; if ({res_cout, res_sum} !== 17'h0_1010 || done_at !== 5) begin
      errors++; $display("FAIL abort_recover: got %b/%h at=%0d want 0/1010 at=5", res_cout, res_sum, done_at);
    end
  endtask

`ifdef NIBBLE_ADDER_SEQ_OVF_EN
  task automatic test_ovf();
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    checks++; if ({res_ovf, res_cout, res_sum} !== 18'b1_0_1000_0000_0000_0000) begin
      errors++; $display("FAIL ovf_pos: got ovf=%b cout=%b sum=%h want 1 0 8000", res_ovf, res_cout, res_sum);
    end
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", bus.ovf); end
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    checks++; if (res_ovf !== 1'b0 || res_cout !== 1'b1) begin
      errors++; $display("FAIL ovf_neg: got ovf=%b cout=%b want 0 1", res_ovf, res_cout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_cin();
    test_start_ignored();
    test_reset_mid_run();
`ifdef NIBBLE_ADDER_SEQ_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
